// File: rtl/imm_encoder_if.sv
// Request/response bundle for imm_encoder: a value+mode request channel and a field+ok result channel.
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_field;
    logic        out_ok;

    modport master (
        output in_valid, in_value, in_mode, out_ready,
        input  in_ready, out_valid, out_field, out_ok
    );

    modport slave (
        input  in_valid, in_value, in_mode, out_ready,
        output in_ready, out_valid, out_field, out_ok
    );
endinterface

// File: rtl/imm_encoder.sv
// Inverse immediate extender: turns a 32-bit value plus ImmSrc mode into Instr[23:0] or flags it unencodable.
// Define IMM_ENC_PARALLEL_EN to test every rotation in the accept cycle instead of the serial SEARCH walk.
module imm_encoder #(
    parameter int MAX_ROT = 15
) (
    input logic           clk,
    input logic           reset,
    imm_encoder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] ROT_LAST = 4'(MAX_ROT);

    state_t      state_q, state_d;
    logic [31:0] value_q, value_d;
    logic [3:0]  rot_q,   rot_d;
    logic [23:0] field_q, field_d;
    logic        ok_q,    ok_d;
    logic [31:0] searchCand;

    // Rotating left by 2*rot undoes the extender's rotate-right, so a hit leaves only imm8 set.
    function automatic logic [31:0] rotLeft(input logic [31:0] v, input logic [3:0] rot);
        logic [63:0] both;
        both = {v, v} << {rot, 1'b0};
        return both[63:32];
    endfunction

    assign searchCand = rotLeft(value_q, rot_q);

`ifdef IMM_ENC_PARALLEL_EN
    logic        parOk;
    logic [23:0] parField;
    logic [31:0] parCand;

    // Walk from the highest rotation down so the lowest matching rotation is the one left standing.
    always_comb begin
        parOk    = 1'b0;
        parField = '0;
        parCand  = '0;
        for (int r = MAX_ROT; r >= 0; r--) begin
            parCand = rotLeft(bus.in_value, 4'(r));
            if (parCand[31:8] == 24'd0) begin
                parOk    = 1'b1;
                parField = {12'b0, 4'(r), parCand[7:0]};
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            value_q <= '0;
            rot_q   <= '0;
            field_q <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            rot_q   <= rot_d;
            field_q <= field_d;
            ok_q    <= ok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        rot_d   = rot_q;
        field_d = field_q;
        ok_d    = ok_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    value_d = bus.in_value;
                    rot_d   = '0;
                    field_d = '0;
                    ok_d    = 1'b0;
                    state_d = DONE;
                    case (bus.in_mode)
                        2'b00: begin
`ifdef IMM_ENC_PARALLEL_EN
                            field_d = parField;
                            ok_d    = parOk;
`else
                            state_d = SEARCH;
`endif
                        end
                        2'b01: begin
                            if (bus.in_value[31:12] == 20'd0) begin
                                ok_d    = 1'b1;
                                field_d = {12'b0, bus.in_value[11:0]};
                            end
                        end
                        2'b10: begin
                            // Word-aligned and representable as a sign-extended 24-bit word offset.
                            if (bus.in_value[1:0] == 2'b00 &&
                                bus.in_value[31:25] == {7{bus.in_value[25]}}) begin
                                ok_d    = 1'b1;
                                field_d = bus.in_value[25:2];
                            end
                        end
                        default: ;
                    endcase
                end
            end
            SEARCH: begin
                if (searchCand[31:8] == 24'd0) begin
                    field_d = {12'b0, rot_q, searchCand[7:0]};
                    ok_d    = 1'b1;
                    state_d = DONE;
                end else if (rot_q == ROT_LAST) begin
                    field_d = '0;
                    ok_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    rot_d = rot_q + 4'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    field_d = '0;
                    ok_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_field = field_q;
    assign bus.out_ok    = ok_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed requests queue expected results, a negedge monitor checks them.
module tb_imm_encoder;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    imm_encoder_if bus ();
    imm_encoder_if bus3 ();

    imm_encoder #(.MAX_ROT(15)) dut  (.clk(clk), .reset(reset), .bus(bus));
    imm_encoder #(.MAX_ROT(3))  dut3 (.clk(clk), .reset(reset), .bus(bus3));

    typedef struct {
        string       name;
        logic [23:0] field;
        logic        ok;
        int          lat;
        int          accept;
    } expItem_t;

    expItem_t expQ[$];
    expItem_t cur;
    bit       curValid = 1'b0;
    bit       holding  = 1'b0;
    int       tbCycle  = 0;
    int       assertCount = 0;
    int       failCount   = 0;

    always @(posedge clk) tbCycle <= tbCycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        assertCount++;
        failCount++;
        $display("[TB] FAIL %s: got timeout, expected response", name);
    endtask

    // Only mode-00 requests get faster in the parallel build; everything else is one cycle either way.
    function automatic int expLat(input int serialLat);
`ifdef IMM_ENC_PARALLEL_EN
        return 1;
`else
        return serialLat;
`endif
    endfunction

    task automatic applyStimulus(input string name, input logic [31:0] value, input logic [1:0] mode,
                                 input logic [23:0] field, input logic ok, input int serialLat,
                                 input bit expectOut);
        bit       ready = 1'b0;
        expItem_t item;
        for (int i = 0; i < 100 && !ready; i++) begin
            @(negedge clk);
            if (bus.in_ready) ready = 1'b1;
        end
        if (!ready) begin
            reportTimeout({name, "/in_ready"});
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_value = value;
        bus.in_mode  = mode;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (expectOut) begin
            item.name   = name;
            item.field  = field;
            item.ok     = ok;
            item.lat    = expLat(serialLat);
            item.accept = tbCycle;
            expQ.push_back(item);
        end
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 300 && (expQ.size() != 0 || holding); i++) @(negedge clk);
        if (expQ.size() != 0 || holding) reportTimeout("drain");
    endtask

    // Pops one expectation per result and re-checks it every cycle the result is held under backpressure.
    always @(negedge clk) begin
        if (reset) begin
            holding  = 1'b0;
            curValid = 1'b0;
        end else if (bus.out_valid) begin
            if (!holding) begin
                if (expQ.size() == 0) begin
                    assertCount++;
                    failCount++;
                    curValid = 1'b0;
                    $display("[TB] FAIL unexpected_output: got field 0x%06h ok %0b, expected no output",
                             bus.out_field, bus.out_ok);
                end else begin
                    cur      = expQ.pop_front();
                    curValid = 1'b1;
                    checkOutput({cur.name, "/field"}, 32'(bus.out_field), 32'(cur.field));
                    checkOutput({cur.name, "/ok"}, 32'(bus.out_ok), 32'(cur.ok));
                    checkOutput({cur.name, "/latency"}, 32'(tbCycle - cur.accept + 1), 32'(cur.lat));
                end
                holding = 1'b1;
            end else if (curValid) begin
                checkOutput({cur.name, "/held_field"}, 32'(bus.out_field), 32'(cur.field));
                checkOutput({cur.name, "/held_ok"}, 32'(bus.out_ok), 32'(cur.ok));
            end
            if (bus.out_ready) holding = 1'b0;
        end
    end

    initial begin
        int  a3;
        int  lat3;
        bit  got3;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_value  = '0;
        bus.in_mode   = '0;
        bus.out_ready = 1'b1;
        bus3.in_valid  = 1'b0;
        bus3.in_value  = '0;
        bus3.in_mode   = '0;
        bus3.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        checkOutput("reset/in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset/out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset/out_field", 32'(bus.out_field), 32'd0);
        checkOutput("reset/out_ok", 32'(bus.out_ok), 32'd0);

        applyStimulus("m00_ff",       32'h0000_00FF, 2'b00, 24'h0000FF, 1'b1, 2,  1'b1);
        applyStimulus("m00_ff000000", 32'hFF00_0000, 2'b00, 24'h0004FF, 1'b1, 6,  1'b1);
        applyStimulus("m00_101",      32'h0000_0101, 2'b00, 24'h000000, 1'b0, 17, 1'b1);
        applyStimulus("m00_zero",     32'h0000_0000, 2'b00, 24'h000000, 1'b1, 2,  1'b1);
        applyStimulus("m00_wrap",     32'hC000_003F, 2'b00, 24'h0001FF, 1'b1, 3,  1'b1);
        applyStimulus("m00_rot15",    32'h0000_03FC, 2'b00, 24'h000FFF, 1'b1, 17, 1'b1);
        applyStimulus("m01_fff",      32'h0000_0FFF, 2'b01, 24'h000FFF, 1'b1, 1,  1'b1);
        applyStimulus("m01_1000",     32'h0000_1000, 2'b01, 24'h000000, 1'b0, 1,  1'b1);
        applyStimulus("m10_neg",      32'hFFFF_FFF8, 2'b10, 24'hFFFFFE, 1'b1, 1,  1'b1);
        applyStimulus("m10_unalign",  32'h0000_0006, 2'b10, 24'h000000, 1'b0, 1,  1'b1);
        applyStimulus("m10_range",    32'h0200_0000, 2'b10, 24'h000000, 1'b0, 1,  1'b1);
        applyStimulus("m10_maxpos",   32'h01FF_FFFC, 2'b10, 24'h7FFFFF, 1'b1, 1,  1'b1);
        applyStimulus("m11_illegal",  32'h0000_00FF, 2'b11, 24'h000000, 1'b0, 1,  1'b1);
        waitDrain();

        // Reset lands while the unencodable search is still running: the request must vanish.
        applyStimulus("reset_mid", 32'h0000_0101, 2'b00, 24'h000000, 1'b0, 17, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_mid/in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset_mid/out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_mid/out_ok", 32'(bus.out_ok), 32'd0);
        repeat (20) @(negedge clk);

        bus.out_ready = 1'b0;
        applyStimulus("bp_m01", 32'h0000_0FFF, 2'b01, 24'h000FFF, 1'b1, 1, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_value = 32'h0000_0123;
        bus.in_mode  = 2'b01;
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp/in_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("bp/out_valid", 32'(bus.out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        waitDrain();
        repeat (5) @(negedge clk);

        @(negedge clk);
        bus3.in_valid = 1'b1;
        bus3.in_value = 32'hFF00_0000;
        bus3.in_mode  = 2'b00;
        @(posedge clk);
        #1;
        bus3.in_valid = 1'b0;
        a3   = tbCycle;
        got3 = 1'b0;
        lat3 = 0;
        for (int i = 0; i < 40 && !got3; i++) begin
            @(negedge clk);
            if (bus3.out_valid) begin
                got3 = 1'b1;
                lat3 = tbCycle - a3 + 1;
            end
        end
        if (!got3) begin
            reportTimeout("maxrot3/out_valid");
        end else begin
            checkOutput("maxrot3/latency", 32'(lat3), 32'(expLat(5)));
            checkOutput("maxrot3/ok", 32'(bus3.out_ok), 32'd0);
            checkOutput("maxrot3/field", 32'(bus3.out_field), 32'd0);
        end
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
